// File: rtl/atm_txn_sequencer_if.sv
// atm_txn_sequencer_if: request/response handshakes and ledger RAM port of the ATM transaction sequencer.
interface atm_txn_sequencer_if #(
    parameter int ACCT_W = 4,
    parameter int AMT_W  = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_select;
    logic [ACCT_W-1:0] req_origin;
    logic [ACCT_W-1:0] req_purpose;
    logic [AMT_W-1:0]  req_amount;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_result;
    logic [AMT_W-1:0]  rsp_balance;
    logic              mem_rd_en;
    logic [ACCT_W-1:0] mem_rd_addr;
    logic [AMT_W-1:0]  mem_rd_data;
    logic              mem_wr_en;
    logic [ACCT_W-1:0] mem_wr_addr;
    logic [AMT_W-1:0]  mem_wr_data;

    modport slave (
        input  req_valid, req_select, req_origin, req_purpose, req_amount, rsp_ready, mem_rd_data,
        output req_ready, rsp_valid, rsp_result, rsp_balance, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
    );
    modport master (
        output req_valid, req_select, req_origin, req_purpose, req_amount, rsp_ready, mem_rd_data,
        input  req_ready, rsp_valid, rsp_result, rsp_balance, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/atm_txn_sequencer.sv
// atm_txn_sequencer: read-check-write ledger transaction controller; define ATM_DAILY_LIMIT_EN for the per-session withdrawal cap.
module atm_txn_sequencer #(
    parameter int ACCT_W      = 4,
    parameter int AMT_W       = 10,
    parameter int DAILY_LIMIT = 500
) (
    input  logic               clk,
    input  logic               rst,
    atm_txn_sequencer_if.slave bus,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, RD_O, RD_P, EVAL, WR_O, WR_P, RSP} state_t;

    state_t            r_state, w_next;
    logic [1:0]        r_sel, r_result, w_res;
    logic [ACCT_W-1:0] r_org, r_pur_a;
    logic [AMT_W-1:0]  r_amt, r_orig, r_pur, r_bal, w_bal;
    logic [AMT_W:0]    w_pur_sum;
    logic              w_xfer, w_lim, w_write;

    if (DAILY_LIMIT < 0) begin : g_bad_limit
        $error("DAILY_LIMIT must be non-negative");
    end

    assign w_xfer    = r_sel == 2'b10;
    assign w_pur_sum = {1'b0, bus.mem_rd_data} + {1'b0, r_amt};

`ifdef ATM_DAILY_LIMIT_EN
    logic [AMT_W:0]   r_acc;
    logic [AMT_W+1:0] w_acc_sum;
    assign w_acc_sum = {1'b0, r_acc} + {2'b00, r_amt};
    assign w_lim     = w_acc_sum > (AMT_W+2)'(DAILY_LIMIT);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (r_state == IDLE && bus.req_valid && bus.req_select == 2'b11)
            r_acc <= '0;
        else if (r_state == EVAL && w_write)
            r_acc <= w_acc_sum[AMT_W+1] ? '1 : w_acc_sum[AMT_W:0];
    end
`else
    assign w_lim = 1'b0;
`endif

    // Priority: same account, session limit, funds, purpose overflow.
    assign w_res   = r_sel == 2'b00 ? 2'b01 :
                     (w_xfer && r_org == r_pur_a) ? 2'b10 :
                     w_lim ? 2'b10 :
                     r_amt > r_orig ? 2'b00 :
                     (w_xfer && w_pur_sum[AMT_W]) ? 2'b10 : 2'b01;
    assign w_write = r_sel != 2'b00 && w_res == 2'b01;
    assign w_bal   = w_write ? r_orig - r_amt : r_orig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= '0;
            r_org    <= '0;
            r_pur_a  <= '0;
            r_amt    <= '0;
            r_orig   <= '0;
            r_pur    <= '0;
            r_result <= '0;
            r_bal    <= '0;
        end else begin
            if (r_state == IDLE && bus.req_valid) begin
                r_sel   <= bus.req_select;
                r_org   <= bus.req_origin;
                r_pur_a <= bus.req_purpose;
                r_amt   <= bus.req_amount;
                if (bus.req_select == 2'b11) begin
                    r_result <= 2'b11;
                    r_bal    <= '0;
                end
            end
            if (r_state == RD_P)
                r_orig <= bus.mem_rd_data;
            if (r_state == EVAL) begin
                r_pur    <= w_pur_sum[AMT_W-1:0];
                r_result <= w_res;
                r_bal    <= w_bal;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.req_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    w_next = bus.req_select == 2'b11 ? RSP : RD_O;
            end
            RD_O: begin
                bus.mem_rd_en   = 1'b1;
                bus.mem_rd_addr = r_org;
                w_next          = RD_P;
            end
            RD_P: begin
                bus.mem_rd_en   = w_xfer;
                bus.mem_rd_addr = w_xfer ? r_pur_a : '0;
                w_next          = EVAL;
            end
            EVAL: w_next = w_write ? WR_O : RSP;
            WR_O: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = r_org;
                bus.mem_wr_data = r_bal;
                w_next          = w_xfer ? WR_P : RSP;
            end
            WR_P: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = r_pur_a;
                bus.mem_wr_data = r_pur;
                w_next          = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.rsp_result  = r_result;
    assign bus.rsp_balance = r_bal;
    assign busy            = r_state != IDLE;
endmodule

// File: doc/atm_txn_sequencer.md
Name: atm_txn_sequencer

Overview:
- Transaction controller for the ATM account ledger (16 accounts x 10-bit balances).
- Accepts one request at a time over a valid/ready handshake: select, origin account, purpose account and amount.
- Sequences read-check-write accesses to an external single-read/single-write ledger RAM, then returns a result code and balance over a valid/ready response channel.
- Sits between the terminal front-end and the ledger storage.

Parameters:
- ACCT_W, 4: account number width; ledger depth is 2**ACCT_W.
- AMT_W, 10: balance and amount width, unsigned.
- DAILY_LIMIT, 500: cumulative withdrawal cap per session (used only with ATM_DAILY_LIMIT_EN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_select  in  2  00 balance, 01 withdraw, 10 transfer origin->purpose, 11 exit session.
- req_origin  in  ACCT_W  origin account.
- req_purpose  in  ACCT_W  purpose account (transfer only).
- req_amount  in  AMT_W  amount.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_result  out  2  01 ok, 00 insufficient funds, 10 rejected (overflow/same account/limit), 11 exit acknowledged.
- rsp_balance  out  AMT_W  origin balance after the operation.
- mem_rd_en  out  1  ledger read strobe.
- mem_rd_addr  out  ACCT_W  read address.
- mem_rd_data  in  AMT_W  read data, valid the cycle after mem_rd_en.
- mem_wr_en  out  1  ledger write strobe.
- mem_wr_addr  out  ACCT_W  write address.
- mem_wr_data  out  AMT_W  write data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready=1. Request latches and limit accumulator cleared.
- Accept: a request is accepted on the edge where req_valid && req_ready; cycle T. All request fields are latched on that edge, so later input changes are ignored.
- States: IDLE, RD_O, RD_P, EVAL, WR_O, WR_P, RSP. Memory strobes are decoded from state.
  - IDLE: on accept, go to RSP if select==11, otherwise go to RD_O.
  - RD_O: mem_rd_en=1, addr=origin. Go to RD_P.
  - RD_P: capture origin balance from mem_rd_data. If transfer, mem_rd_en=1, addr=purpose. Go to EVAL.
  - EVAL: if transfer, capture purpose balance. Compute the decision. Go to WR_O if a write is needed, otherwise RSP.
  - WR_O: mem_wr_en=1, addr=origin, data=orig-amount. Go to WR_P if transfer, otherwise RSP.
  - WR_P: mem_wr_en=1, addr=purpose, data=pur+amount. Go to RSP.
  - RSP: rsp_valid=1, outputs held stable until rsp_ready. On the rsp_ready edge, go to IDLE. rsp_valid falls the next cycle and req_ready rises the same cycle.
- Decisions:
  - Balance: result 01; no write.
  - Withdraw: amount <= orig gives 01 with a write; amount > orig gives 00, no write. Equality is allowed and leaves balance 0.
  - Transfer, checked in this priority:
    - origin==purpose: 10.
    - amount > orig: 00.
    - pur+amount > 2**AMT_W-1 (checked in AMT_W+1 bits): 10.
    - otherwise 01 with both writes.
  - Any rejection performs no writes; the ledger is untouched.
  - Amount 0 on withdraw or transfer: 01, writes performed with unchanged values.
- rsp_balance:
  - Balance, and any rejection: orig.
  - Successful withdraw or transfer: orig-amount.
  - Exit: 0.
- Latency from accept cycle T to first rsp_valid cycle:
  - Exit: T+1.
  - Balance and any reject: T+4.
  - Withdraw ok: T+5.
  - Transfer ok: T+6.
- Back-to-back: next accept at the earliest 1 cycle after the RSP handshake. There is no overlap; only one transaction is in flight.
- Reset mid-operation: immediate return to reset values and all strobes deassert.
  - Reset asserted while in WR_P: the origin write has already happened and the purpose write is abandoned. Transfers are not atomic across reset.
  - The pending response is lost.

Optional Feature:
- Macro: ATM_DAILY_LIMIT_EN.
- With the macro defined:
  - An AMT_W+1-bit accumulator sums successful withdraw and transfer amounts, saturating at all-ones.
  - A withdraw or transfer where accumulator+amount > DAILY_LIMIT returns 10 with no write. This check ranks after same-account and before insufficient funds.
  - Exit (11) and reset clear the accumulator.
- Without the macro: no accumulator, no limit check, DAILY_LIMIT is ignored, and all other behaviour is identical.

Test Plan:
- Ledger[3]=109, request balance origin=3, rsp_ready=1 -> rsp_valid at T+4, result 01, balance 109, no mem_wr_en pulse.
- Ledger[0]=214, withdraw 214 from 0 -> write addr 0 data 0 in cycle T+4, result 01, balance 0; then withdraw 1 -> result 00, no write.
- Ledger[1]=502, ledger[10]=73, transfer 100 from 1 to 10 -> writes (1,402) at T+4 and (10,173) at T+5, result 01, balance 402, rsp at T+6.
- Ledger[14]=1023, transfer 1 from 2 to 14 -> result 10, no writes. Transfer origin=purpose=5 -> result 10.
- Hold rsp_ready=0 for 7 cycles -> rsp_valid and outputs stable and req_ready=0 throughout. Assert rst during WR_P of a transfer -> all outputs 0 and req_ready=1 immediately, purpose unchanged.
- ATM_DAILY_LIMIT_EN defined: withdraw 300 then withdraw 250 (sufficient funds) -> 01 then 10. After exit (result 11 at T+1), withdraw 250 -> 01.
